// File: rtl/mux64_rr_sched.sv
// Round-robin scheduler that owns the select of a shared 64:1 bit mux.
// Grants one requester at a time, waits SETTLE cycles, then presents the sampled bit.
module mux64_rr_sched #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] req,
    input  logic        mux_out,
    output logic [5:0]  sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_bit,
    output logic [5:0]  out_idx,
    output logic [63:0] ack,
    output logic        busy
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
        $error("mux64_rr_sched: SETTLE must be in the range 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [5:0]  ptr_q;
    logic [5:0]  sel_q;
    logic        outValid_q;
    logic        outBit_q;
    logic [5:0]  outIdx_q;
    logic [63:0] ack_q;

    logic        grantIdle;
    logic        capture;
    logic        accept;
    logic [5:0]  winner;
    logic [5:0]  cand;
    logic        found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grantIdle) state_d = S_SETTLE;
            S_SETTLE: if (capture)   state_d = S_HOLD;
            S_HOLD:   if (accept)    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        grantIdle = (state_q == S_IDLE) && (|req);
        capture   = (state_q == S_SETTLE) && (cnt_q == 4'd1);
        accept    = (state_q == S_HOLD) && outValid_q && out_ready;
    end

    // Search starts just after the last grant; offset 64 wraps to ptr itself, checked last.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            cand = ptr_q + 6'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= 6'd63;
            outValid_q <= 1'b0;
            outBit_q   <= 1'b0;
            outIdx_q   <= '0;
            ack_q      <= '0;
        end else begin
            ack_q <= '0;
            if (grantIdle) begin
                sel_q <= winner;
                cnt_q <= 4'(SETTLE);
            end
            if (state_q == S_SETTLE) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                outBit_q   <= mux_out;
                outIdx_q   <= sel_q;
                outValid_q <= 1'b1;
                ack_q      <= 64'd1 << sel_q;
                ptr_q      <= sel_q;
            end
            if (accept) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign sel       = sel_q;
    assign out_valid = outValid_q;
    assign out_bit   = outBit_q;
    assign out_idx   = outIdx_q;
    assign ack       = ack_q;

endmodule

// File: doc/mux64_rr_sched.md
Name: mux64_rr_sched

Overview:
- Round-robin scheduler that shares one 64-to-1 bit multiplexer among 64 requesters.
- Each cycle it can, it picks the next requesting channel and drives the mux select. It waits a programmable settle time, then captures the mux output.
- It presents the captured bit and channel index on a valid/ready output port and pulses a one-hot acknowledge back to the winning requester.
- It sits directly beside the mux64_1 instance and owns its select input.

Parameters:
- SETTLE, 1, number of cycles select is held before mux_out is sampled; legal range 1..15; 0 is illegal and is rejected at elaboration.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  64  level request per channel; bit i requests channel i.
- mux_out  input  1  combinational output of the shared mux64_1.
- sel  output  6  select driven to the mux64_1 select input.
- out_valid  output  1  captured result available.
- out_ready  input  1  consumer accepts the result.
- out_bit  output  1  captured mux value.
- out_idx  output  6  channel index the bit belongs to.
- ack  output  64  one-hot, one-cycle pulse to the granted requester.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, active-high), effective immediately, including mid-operation:
  - state=IDLE, sel=0, out_valid=0, out_bit=0, out_idx=0, ack=0, busy=0.
  - Internal last-grant pointer ptr=63, so the first search starts at channel 0.
  - A pending result is discarded.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If req==0, remain in IDLE; sel keeps its last value.
  - Otherwise the winner w is the first set bit of req scanning ptr+1, ptr+2, … modulo 64 (wraps 63→0).
  - Next edge: sel<=w, settle counter<=SETTLE, go to SETTLE.
  - req is sampled only in IDLE.
- SETTLE:
  - sel held constant; counter decrements once per cycle; state lasts exactly SETTLE cycles.
  - On the edge ending the last SETTLE cycle: out_bit<=mux_out, out_idx<=sel, out_valid<=1, ack<=one-hot(sel) for one cycle, ptr<=sel, go to HOLD.
  - Deassertion of req[w] during SETTLE does not abort; the grant completes.
- HOLD:
  - out_valid, out_bit, out_idx and sel remain stable until a cycle with out_valid&&out_ready.
  - On that edge: out_valid<=0, go to IDLE.
  - ack is 0 after its single cycle.
- Latency: req first seen in IDLE at edge N → sel valid after edge N+1 → out_valid rises after edge N+1+SETTLE.
- Throughput: minimum 2+SETTLE cycles per grant (1 IDLE + SETTLE + 1 HOLD) when out_ready is held high.
- Fairness:
  - A channel, once granted, is not granted again while any other channel requests continuously.
  - A single persistent requester is granted back-to-back.
- Boundary conditions:
  - ptr=63 wraps the search to channel 0.
  - All 64 bits requesting gives grants in order ptr+1 onward.
  - out_ready high while out_valid is low has no effect.
  - There is no bypass: IDLE always takes at least one cycle.

Test Plan:
- Reset: assert rst mid-SETTLE with req[7]=1 → sel=0, out_valid=0, ack=0, busy=0 immediately, without a clock edge. After release, req={0,7 set} → first grant is channel 0.
- Single request, SETTLE=2, mux modeled as data[sel] with data=64'h0000_0000_0000_0020, req[5]=1 at edge N → sel=5 after N+1, out_valid=1/out_bit=1/out_idx=5/ack=64'h20 after N+3.
- Round-robin, req bits 3, 40 and 63 held high, out_ready=1 → out_idx sequence 3, 40, 63, 3, 40, with a grant every 4 cycles at SETTLE=2.
- Wrap: after a grant to channel 63, req bits 0 and 62 set → next out_idx=0, then 62.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_valid, out_bit, out_idx and sel stable; ack high for only the first cycle; no new sel. Raising out_ready → out_valid drops next edge and IDLE resumes.
- Request withdrawal: req[9] pulsed for one IDLE cycle then dropped during SETTLE → grant still completes with out_idx=9; afterwards the scheduler idles with busy=0.
